// File: rtl/dcache_assoc_top.sv
// Two-way set-associative, write-back, write-allocate data cache between the CPU
// data port and a line-wide memory. Hits complete combinationally in IDLE.
module dcache_assoc_top #(
  parameter int LINE_W  = 256,
  parameter int INDEX_W = 4,
  parameter int ADDR_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [31:0]       p1_data_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o
);

  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int SETS   = 2 ** INDEX_W;
  localparam int TAG_W  = ADDR_W - OFF_W - INDEX_W;
  localparam int WSEL_W = OFF_W - 2;

  typedef enum logic [2:0] {S_IDLE, S_MISS, S_WB, S_REFILL, S_DONE} state_t;

  state_t r_state, w_nextState;

  logic [SETS-1:0]   r_valid0, r_valid1, r_dirty0, r_dirty1, r_lru;
  logic [TAG_W-1:0]  r_tag0 [SETS];
  logic [TAG_W-1:0]  r_tag1 [SETS];
  logic [LINE_W-1:0] r_data0 [SETS];
  logic [LINE_W-1:0] r_data1 [SETS];

  logic              r_victim;
  logic              r_memEnable, r_memWrite;
  logic [ADDR_W-1:0] r_memAddr;
  logic [LINE_W-1:0] r_memData;

  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_index;
  logic [WSEL_W-1:0]  w_word;
  logic [OFF_W+2:0]   w_bitPos;
  logic               w_unused;
  logic               w_req, w_hit0, w_hit1, w_hit, w_ack;
  logic               w_loadHit, w_storeHit;
  logic [LINE_W-1:0]  w_hitLine;
  logic               w_victim, w_victimDirty;
  logic [TAG_W-1:0]   w_victimTag;
  logic [LINE_W-1:0]  w_victimLine;
  logic [ADDR_W-1:0]  w_lineAddr;

  assign w_tag    = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign w_index  = p1_addr_i[OFF_W +: INDEX_W];
  assign w_word   = p1_addr_i[2 +: WSEL_W];
  assign w_bitPos = {w_word, 5'd0};
  assign w_unused = ^p1_addr_i[1:0];

  assign w_req      = p1_MemRead_i | p1_MemWrite_i;
  assign w_hit0     = r_valid0[w_index] && (r_tag0[w_index] == w_tag);
  assign w_hit1     = r_valid1[w_index] && (r_tag1[w_index] == w_tag);
  assign w_hit      = w_hit0 | w_hit1;
  assign w_loadHit  = (r_state == S_IDLE) & p1_MemRead_i & ~p1_MemWrite_i & w_hit;
  assign w_storeHit = (r_state == S_IDLE) & p1_MemWrite_i & w_hit;
  assign w_hitLine  = w_hit1 ? r_data1[w_index] : r_data0[w_index];

  // An ack only counts while a request is actually outstanding.
  assign w_ack = mem_ack_i & r_memEnable;

  assign w_victim      = ~r_valid0[w_index] ? 1'b0 :
                         ~r_valid1[w_index] ? 1'b1 : r_lru[w_index];
  assign w_victimDirty = w_victim ? (r_valid1[w_index] & r_dirty1[w_index])
                                  : (r_valid0[w_index] & r_dirty0[w_index]);
  assign w_victimTag   = w_victim ? r_tag1[w_index] : r_tag0[w_index];
  assign w_victimLine  = w_victim ? r_data1[w_index] : r_data0[w_index];
  assign w_lineAddr    = {w_tag, w_index, {OFF_W{1'b0}}};

  assign p1_data_o    = w_loadHit ? w_hitLine[w_bitPos +: 32] : 32'd0;
  assign p1_stall_o   = (w_req & ~w_hit) | (r_state != S_IDLE);
  assign mem_enable_o = r_memEnable;
  assign mem_write_o  = r_memWrite;
  assign mem_addr_o   = r_memAddr;
  assign mem_data_o   = r_memData;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (w_req && !w_hit) w_nextState = S_MISS;
      S_MISS:   w_nextState = w_victimDirty ? S_WB : S_REFILL;
      S_WB:     if (w_ack) w_nextState = S_REFILL;
      S_REFILL: if (w_ack) w_nextState = S_DONE;
      S_DONE:   w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // Metadata and memory-request registers; the request drops for one cycle
  // between a writeback and its refill so each request ends with its own ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid0    <= '0;
      r_valid1    <= '0;
      r_dirty0    <= '0;
      r_dirty1    <= '0;
      r_lru       <= '0;
      r_victim    <= 1'b0;
      r_memEnable <= 1'b0;
      r_memWrite  <= 1'b0;
      r_memAddr   <= '0;
      r_memData   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_loadHit || w_storeHit) r_lru[w_index] <= ~w_hit1;
          if (w_storeHit) begin
            if (w_hit1) r_dirty1[w_index] <= 1'b1;
            else        r_dirty0[w_index] <= 1'b1;
          end
        end
        S_MISS: begin
          r_victim    <= w_victim;
          r_memEnable <= 1'b1;
          if (w_victimDirty) begin
            r_memWrite <= 1'b1;
            r_memAddr  <= {w_victimTag, w_index, {OFF_W{1'b0}}};
            r_memData  <= w_victimLine;
          end else begin
            r_memWrite <= 1'b0;
            r_memAddr  <= w_lineAddr;
          end
        end
        S_WB: begin
          if (w_ack) begin
            r_memEnable <= 1'b0;
            r_memWrite  <= 1'b0;
            r_memAddr   <= w_lineAddr;
          end
        end
        S_REFILL: begin
          if (!r_memEnable) begin
            r_memEnable <= 1'b1;
          end else if (w_ack) begin
            r_memEnable <= 1'b0;
            if (r_victim) begin
              r_valid1[w_index] <= 1'b1;
              r_dirty1[w_index] <= 1'b0;
            end else begin
              r_valid0[w_index] <= 1'b1;
              r_dirty0[w_index] <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (r_state == S_REFILL && w_ack) begin
      if (r_victim) begin
        r_data1[w_index] <= mem_data_i;
        r_tag1[w_index]  <= w_tag;
      end else begin
        r_data0[w_index] <= mem_data_i;
        r_tag0[w_index]  <= w_tag;
      end
    end else if (w_storeHit) begin
      if (w_hit1) r_data1[w_index][w_bitPos +: 32] <= p1_data_i;
      else        r_data0[w_index][w_bitPos +: 32] <= p1_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_assoc_top.sv
// Directed self-checking bench for dcache_assoc_top (LINE_W=256, INDEX_W=4).
module tb_dcache_assoc_top;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  p1_data_i;
  logic [31:0]  p1_addr_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;

  int testsRun  = 0;
  int failCount = 0;

  dcache_assoc_top #(.LINE_W(256), .INDEX_W(4), .ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .p1_data_i(p1_data_i), .p1_addr_i(p1_addr_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [255:0] makeLine(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + i;
    return l;
  endfunction

  function automatic logic [255:0] setWord(input logic [255:0] line, input int idx,
                                           input logic [31:0] w);
    logic [255:0] l;
    l = line;
    l[idx*32 +: 32] = w;
    return l;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data);
    p1_MemRead_i  = rd;
    p1_MemWrite_i = wr;
    p1_addr_i     = addr;
    p1_data_i     = data;
    #1;
  endtask

  task automatic nextCycle();
    @(negedge clk_i);
    #1;
  endtask

  task automatic waitEnable(input string tag, output int cycles);
    cycles = 0;
    while (!mem_enable_o && cycles < 50) begin
      nextCycle();
      cycles++;
    end
    checkOutput(tag, mem_enable_o, 1'b1);
  endtask

  task automatic ackMem(input logic [255:0] line);
    mem_data_i = line;
    mem_ack_i  = 1'b1;
    @(negedge clk_i);
    mem_ack_i  = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    logic [255:0] lineA, lineB, lineC, lineD, lineE, wbLine;
    int cycles;

    lineA = setWord(makeLine(32'h1000_0000), 1, 32'hDEAD_BEEF);
    lineB = makeLine(32'h2000_0000);
    lineC = makeLine(32'h3000_0000);
    lineD = makeLine(32'h4000_0000);
    lineE = makeLine(32'h5000_0000);

    rst_i = 1'b1;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checkOutput("reset_enable", mem_enable_o, 1'b0);
    checkOutput("reset_write", mem_write_o, 1'b0);
    checkOutput("reset_addr", mem_addr_o, 32'h0);
    checkOutput("reset_memdata", mem_data_o, 256'h0);
    checkOutput("reset_stall", p1_stall_o, 1'b0);
    checkOutput("reset_data", p1_data_o, 32'h0);

    // Cold load miss, clean refill.
    applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    checkOutput("t1_stall", p1_stall_o, 1'b1);
    waitEnable("t1_enable", cycles);
    checkOutput("t1_latency", cycles, 2);
    checkOutput("t1_write", mem_write_o, 1'b0);
    checkOutput("t1_addr", mem_addr_o, 32'h0000_0040);
    ackMem(lineA);
    checkOutput("t1_done_stall", p1_stall_o, 1'b1);
    checkOutput("t1_enable_drop", mem_enable_o, 1'b0);
    nextCycle();
    checkOutput("t1_hit_stall", p1_stall_o, 1'b0);
    checkOutput("t1_word0", p1_data_o, 32'h1000_0000);
    applyStimulus(1'b1, 1'b0, 32'h0000_0044, 32'h0);
    checkOutput("t1_word1", p1_data_o, 32'hDEAD_BEEF);

    // Store hit, readback, idle output.
    applyStimulus(1'b0, 1'b1, 32'h0000_0048, 32'h1234_5678);
    checkOutput("t2_store_stall", p1_stall_o, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0000_0048, 32'h0);
    checkOutput("t2_load_stall", p1_stall_o, 1'b0);
    checkOutput("t2_load_data", p1_data_o, 32'h1234_5678);
    applyStimulus(1'b0, 1'b0, 32'h0000_0048, 32'h0);
    checkOutput("t2_noreq_data", p1_data_o, 32'h0);
    checkOutput("t2_noreq_stall", p1_stall_o, 1'b0);
    nextCycle();

    // Fill both ways of set 2, touch 0x40, then evict LRU (0x4040).
    applyStimulus(1'b1, 1'b0, 32'h0000_4040, 32'h0);
    waitEnable("t3_enable_a", cycles);
    checkOutput("t3_addr_a", mem_addr_o, 32'h0000_4040);
    checkOutput("t3_write_a", mem_write_o, 1'b0);
    ackMem(lineB);
    nextCycle();
    checkOutput("t3_data_a", p1_data_o, 32'h2000_0000);
    applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    checkOutput("t3_touch_stall", p1_stall_o, 1'b0);
    checkOutput("t3_touch_data", p1_data_o, 32'h1000_0000);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0000_8040, 32'h0);
    checkOutput("t3_miss_stall", p1_stall_o, 1'b1);
    waitEnable("t3_enable_b", cycles);
    checkOutput("t3_victim_clean", mem_write_o, 1'b0);
    checkOutput("t3_addr_b", mem_addr_o, 32'h0000_8040);
    ackMem(lineC);
    nextCycle();
    checkOutput("t3_data_b", p1_data_o, 32'h3000_0000);
    applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    checkOutput("t3_survivor_stall", p1_stall_o, 1'b0);
    checkOutput("t3_survivor_data", p1_data_o, 32'h1000_0000);
    nextCycle();

    // Store miss into 0x4044, then force its dirty eviction.
    applyStimulus(1'b0, 1'b1, 32'h0000_4044, 32'hCAFE_F00D);
    checkOutput("t4_evicted_stall", p1_stall_o, 1'b1);
    waitEnable("t4_enable_a", cycles);
    checkOutput("t4_write_a", mem_write_o, 1'b0);
    checkOutput("t4_addr_a", mem_addr_o, 32'h0000_4040);
    ackMem(lineB);
    nextCycle();
    checkOutput("t4_store_stall", p1_stall_o, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    checkOutput("t4_touch_stall", p1_stall_o, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0000_C040, 32'h0);
    waitEnable("t4_enable_wb", cycles);
    checkOutput("t4_wb_latency", cycles, 2);
    checkOutput("t4_wb_write", mem_write_o, 1'b1);
    checkOutput("t4_wb_addr", mem_addr_o, 32'h0000_4040);
    wbLine = setWord(lineB, 1, 32'hCAFE_F00D);
    checkOutput("t4_wb_data", mem_data_o, wbLine);

    // Slow memory: request must hold steady.
    for (int i = 0; i < 20; i++) begin
      nextCycle();
      checkOutput("t6_hold_enable", mem_enable_o, 1'b1);
      checkOutput("t6_hold_addr", mem_addr_o, 32'h0000_4040);
      checkOutput("t6_hold_data", mem_data_o, wbLine);
      checkOutput("t6_hold_stall", p1_stall_o, 1'b1);
    end
    ackMem(256'h0);
    checkOutput("t4_wb_drop", mem_enable_o, 1'b0);
    nextCycle();
    checkOutput("t4_refill_enable", mem_enable_o, 1'b1);
    checkOutput("t4_refill_write", mem_write_o, 1'b0);
    checkOutput("t4_refill_addr", mem_addr_o, 32'h0000_C040);
    ackMem(lineD);
    checkOutput("t4_done_stall", p1_stall_o, 1'b1);
    nextCycle();
    checkOutput("t4_final_stall", p1_stall_o, 1'b0);
    checkOutput("t4_final_data", p1_data_o, 32'h4000_0000);

    // Reset in the middle of a refill.
    applyStimulus(1'b1, 1'b0, 32'h0000_0060, 32'h0);
    waitEnable("t5_enable", cycles);
    checkOutput("t5_addr", mem_addr_o, 32'h0000_0060);
    rst_i = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0000_0060, 32'h0);
    checkOutput("t5_rst_enable", mem_enable_o, 1'b0);
    checkOutput("t5_rst_addr", mem_addr_o, 32'h0);
    checkOutput("t5_rst_write", mem_write_o, 1'b0);
    checkOutput("t5_rst_stall", p1_stall_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    ackMem(lineB);
    checkOutput("t5_stray_enable", mem_enable_o, 1'b0);
    checkOutput("t5_stray_stall", p1_stall_o, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0000_C040, 32'h0);
    checkOutput("t5_resident_miss", p1_stall_o, 1'b1);
    waitEnable("t5_enable_b", cycles);
    checkOutput("t5_clean_after_rst", mem_write_o, 1'b0);
    checkOutput("t5_addr_b", mem_addr_o, 32'h0000_C040);
    ackMem(lineE);
    nextCycle();
    checkOutput("t5_final_data", p1_data_o, 32'h5000_0000);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
